dmem_port_arbiter: RTL and testbench

- Shares the single-port synchronous data memory between instruction fetch (read-only) and the load/store unit (read/write with byte mask).
- Sits between the LSU address/byte-mask outputs (write_en_bm, storevalue_word, read/write address) plus the IF PC port on one side, and the memory macro on the other.
- Non-pipelined: one transaction in flight; valid/ready request handshake, single-cycle response pulse. Requesters stall on ready low.

---
 rtl/dmem_port_arbiter_pkg.sv | 41 ++++
 rtl/dmem_port_arbiter_rr_arb2.sv | 57 +++++
 rtl/dmem_port_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_dmem_port_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_port_arbiter_pkg.sv
// Shared types and constants for the data-memory port arbiter.
// Holds the FSM state codes, requester source codes, the request
// payload struct and the default memory read latency.
package dmem_port_arbiter_pkg;

  localparam int unsigned ADDR_W      = 32;
  localparam int unsigned DATA_W      = 32;
  localparam int unsigned BM_W        = 4;
  localparam int unsigned CNT_W       = 4;
  localparam int unsigned DEF_MEM_LAT = 2;

  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2,
    ARB_RESP  = 2'd3
  } arb_state_e;

  typedef enum logic {
    SRC_IF = 1'b0,
    SRC_LS = 1'b1
  } src_e;

  // Request selected by the arbiter in the accept cycle.
  typedef struct packed {
    src_e              src;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [BM_W-1:0]   bm;
  } mem_req_t;

  // Word-align a byte address; lane selection is left to the LSU.
  function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] a);
    return a & ~(ADDR_W'(32'd3));
  endfunction

endpackage

// File: rtl/dmem_port_arbiter_rr_arb2.sv
// Two-requester grant (fetch vs. LSU) with a last-grant register.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   prio_mode           0 = round-robin on ties, 1 = LSU always wins ties
//   en                  grants may only be issued while high
//   req_if, req_ls      request valids
//   gnt_if_c, gnt_ls_c  combinational one-hot grants (accept this cycle)
module dmem_port_arbiter_rr_arb2
  import dmem_port_arbiter_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic prio_mode,
  input  logic en,
  input  logic req_if,
  input  logic req_ls,
  output logic gnt_if_c,
  output logic gnt_ls_c
);

  src_e last_grant_q;
  src_e last_grant_d;

  // Grant decode; on a tie the side not granted last wins unless LSU has priority.
  always_comb begin
    gnt_if_c     = DISABLE;
    gnt_ls_c     = DISABLE;
    last_grant_d = last_grant_q;
    if (en) begin
      if (req_if && req_ls) begin
        if (prio_mode || (last_grant_q == SRC_IF)) begin
          gnt_ls_c = ENABLE;
        end else begin
          gnt_if_c = ENABLE;
        end
      end else begin
        gnt_if_c = req_if;
        gnt_ls_c = req_ls;
      end
      if (gnt_ls_c) begin
        last_grant_d = SRC_LS;
      end else if (gnt_if_c) begin
        last_grant_d = SRC_IF;
      end
    end
  end

  // Reset to IF so the LSU wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= SRC_IF;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares a single-port synchronous data memory between instruction fetch
// (read-only) and the load/store unit. One transaction in flight:
// IDLE (accept) -> ISSUE (strobe) -> [WAIT (read latency)] -> RESP (pulse).
// Ports:
//   clk, rst_n                         clock, async active-low reset
//   if_req_*  / if_rsp_*               fetch request handshake and response
//   ls_req_*  / ls_rsp_*               LSU request handshake and response
//   mem_addr, mem_re, mem_we_bm,
//   mem_wdata, mem_rdata               memory macro interface
// Request readies are combinational and only asserted in IDLE; every other
// output is registered.
module dmem_port_arbiter
  import dmem_port_arbiter_pkg::*;
#(
  parameter int unsigned MEM_LAT   = DEF_MEM_LAT,
  parameter int unsigned PRIO_MODE = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req_valid,
  input  logic [ADDR_W-1:0] if_req_addr,
  output logic              if_req_ready,
  output logic              if_rsp_valid,
  output logic [DATA_W-1:0] if_rsp_data,
  input  logic              ls_req_valid,
  input  logic              ls_req_we,
  input  logic [ADDR_W-1:0] ls_req_addr,
  input  logic [DATA_W-1:0] ls_req_wdata,
  input  logic [BM_W-1:0]   ls_req_bm,
  output logic              ls_req_ready,
  output logic              ls_rsp_valid,
  output logic [DATA_W-1:0] ls_rsp_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  output logic [BM_W-1:0]   mem_we_bm,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  arb_state_e        state_q,        state_d;
  src_e              src_q,          src_d;
  logic              we_q,           we_d;
  logic [CNT_W-1:0]  cnt_q,          cnt_d;
  logic [ADDR_W-1:0] mem_addr_q,     mem_addr_d;
  logic              mem_re_q,       mem_re_d;
  logic [BM_W-1:0]   mem_we_bm_q,    mem_we_bm_d;
  logic [DATA_W-1:0] mem_wdata_q,    mem_wdata_d;
  logic              if_rsp_valid_q, if_rsp_valid_d;
  logic [DATA_W-1:0] if_rsp_data_q,  if_rsp_data_d;
  logic              ls_rsp_valid_q, ls_rsp_valid_d;
  logic [DATA_W-1:0] ls_rsp_data_q,  ls_rsp_data_d;

  logic     arb_en;
  logic     gnt_if_c;
  logic     gnt_ls_c;
  mem_req_t req_sel;

  // Gate with rst_n so no ready is visible while reset is held.
  assign arb_en = (state_q == ARB_IDLE) && rst_n;

  dmem_port_arbiter_rr_arb2 u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .prio_mode (PRIO_MODE != 0),
    .en        (arb_en),
    .req_if    (if_req_valid),
    .req_ls    (ls_req_valid),
    .gnt_if_c  (gnt_if_c),
    .gnt_ls_c  (gnt_ls_c)
  );

  // A fetch never carries write intent, whatever the ls_* inputs show.
  always_comb begin
    if (gnt_ls_c) begin
      req_sel = '{src: SRC_LS, we: ls_req_we, addr: ls_req_addr,
                  wdata: ls_req_wdata, bm: ls_req_bm};
    end else begin
      req_sel = '{src: SRC_IF, we: 1'b0, addr: if_req_addr,
                  wdata: '0, bm: '0};
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d        = state_q;
    src_d          = src_q;
    we_d           = we_q;
    cnt_d          = cnt_q;
    mem_addr_d     = mem_addr_q;
    mem_re_d       = DISABLE;
    mem_we_bm_d    = '0;
    mem_wdata_d    = mem_wdata_q;
    if_rsp_valid_d = DISABLE;
    if_rsp_data_d  = if_rsp_data_q;
    ls_rsp_valid_d = DISABLE;
    ls_rsp_data_d  = ls_rsp_data_q;

    unique case (state_q)
      ARB_IDLE: begin
        // Strobes are loaded here so they are high for exactly the ISSUE cycle.
        if (gnt_if_c || gnt_ls_c) begin
          state_d    = ARB_ISSUE;
          src_d      = req_sel.src;
          we_d       = req_sel.we;
          mem_addr_d = word_addr(req_sel.addr);
          if (req_sel.we) begin
            mem_we_bm_d = req_sel.bm;
            mem_wdata_d = req_sel.wdata;
          end else begin
            mem_re_d = ENABLE;
          end
        end
      end
      ARB_ISSUE: begin
        // Stores complete at the write; the ack pulse lands in RESP.
        if (we_q) begin
          state_d        = ARB_RESP;
          ls_rsp_valid_d = ENABLE;
          ls_rsp_data_d  = '0;
        end else begin
          state_d = ARB_WAIT;
          cnt_d   = CNT_W'(MEM_LAT - 1);
        end
      end
      ARB_WAIT: begin
        // mem_rdata is only captured in the final WAIT cycle.
        if (cnt_q == '0) begin
          state_d = ARB_RESP;
          if (src_q == SRC_IF) begin
            if_rsp_valid_d = ENABLE;
            if_rsp_data_d  = mem_rdata;
          end else begin
            ls_rsp_valid_d = ENABLE;
            ls_rsp_data_d  = mem_rdata;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ARB_RESP: begin
        state_d = ARB_IDLE;
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  // State and output registers; reset drops any transaction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ARB_IDLE;
      src_q          <= SRC_IF;
      we_q           <= 1'b0;
      cnt_q          <= '0;
      mem_addr_q     <= '0;
      mem_re_q       <= 1'b0;
      mem_we_bm_q    <= '0;
      mem_wdata_q    <= '0;
      if_rsp_valid_q <= 1'b0;
      if_rsp_data_q  <= '0;
      ls_rsp_valid_q <= 1'b0;
      ls_rsp_data_q  <= '0;
    end else begin
      state_q        <= state_d;
      src_q          <= src_d;
      we_q           <= we_d;
      cnt_q          <= cnt_d;
      mem_addr_q     <= mem_addr_d;
      mem_re_q       <= mem_re_d;
      mem_we_bm_q    <= mem_we_bm_d;
      mem_wdata_q    <= mem_wdata_d;
      if_rsp_valid_q <= if_rsp_valid_d;
      if_rsp_data_q  <= if_rsp_data_d;
      ls_rsp_valid_q <= ls_rsp_valid_d;
      ls_rsp_data_q  <= ls_rsp_data_d;
    end
  end

  assign if_req_ready = gnt_if_c;
  assign ls_req_ready = gnt_ls_c;
  assign if_rsp_valid = if_rsp_valid_q;
  assign if_rsp_data  = if_rsp_data_q;
  assign ls_rsp_valid = ls_rsp_valid_q;
  assign ls_rsp_data  = ls_rsp_data_q;
  assign mem_addr     = mem_addr_q;
  assign mem_re       = mem_re_q;
  assign mem_we_bm    = mem_we_bm_q;
  assign mem_wdata    = mem_wdata_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter. Four instances share the inputs:
//   0: MEM_LAT=2  round-robin   1: MEM_LAT=2  LSU priority
//   2: MEM_LAT=1  round-robin   3: MEM_LAT=15 round-robin
// Inputs change #1 after the rising edge; outputs are sampled on the falling edge.
module tb_dmem_port_arbiter;

  localparam int unsigned N_DUT = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req_valid;
  logic [31:0] if_req_addr;
  logic        ls_req_valid;
  logic        ls_req_we;
  logic [31:0] ls_req_addr;
  logic [31:0] ls_req_wdata;
  logic [3:0]  ls_req_bm;
  logic [31:0] mem_rdata;

  logic        if_req_ready [N_DUT];
  logic        if_rsp_valid [N_DUT];
  logic [31:0] if_rsp_data  [N_DUT];
  logic        ls_req_ready [N_DUT];
  logic        ls_rsp_valid [N_DUT];
  logic [31:0] ls_rsp_data  [N_DUT];
  logic [31:0] mem_addr     [N_DUT];
  logic        mem_re       [N_DUT];
  logic [3:0]  mem_we_bm    [N_DUT];
  logic [31:0] mem_wdata    [N_DUT];

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < N_DUT; g++) begin : g_dut
    dmem_port_arbiter #(
      .MEM_LAT   ((g == 3) ? 15 : ((g == 2) ? 1 : 2)),
      .PRIO_MODE ((g == 1) ? 1 : 0)
    ) u_dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .if_req_valid (if_req_valid),
      .if_req_addr  (if_req_addr),
      .if_req_ready (if_req_ready[g]),
      .if_rsp_valid (if_rsp_valid[g]),
      .if_rsp_data  (if_rsp_data[g]),
      .ls_req_valid (ls_req_valid),
      .ls_req_we    (ls_req_we),
      .ls_req_addr  (ls_req_addr),
      .ls_req_wdata (ls_req_wdata),
      .ls_req_bm    (ls_req_bm),
      .ls_req_ready (ls_req_ready[g]),
      .ls_rsp_valid (ls_rsp_valid[g]),
      .ls_rsp_data  (ls_rsp_data[g]),
      .mem_addr     (mem_addr[g]),
      .mem_re       (mem_re[g]),
      .mem_we_bm    (mem_we_bm[g]),
      .mem_wdata    (mem_wdata[g]),
      .mem_rdata    (mem_rdata)
    );
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    if_req_valid = 1'b0;
    if_req_addr  = '0;
    ls_req_valid = 1'b0;
    ls_req_we    = 1'b0;
    ls_req_addr  = '0;
    ls_req_wdata = '0;
    ls_req_bm    = '0;
    mem_rdata    = '0;
  endtask

  // Leaves the bench #1 into the first cycle after reset release.
  task automatic do_reset();
    nxt();
    rst_n = 1'b0;
    idle_inputs();
    nxt();
    nxt();
    rst_n = 1'b1;
  endtask

  task automatic chk_quiet0(input string tag);
    chk({tag, "_if_ready"}, 32'(if_req_ready[0]), 32'd0);
    chk({tag, "_ls_ready"}, 32'(ls_req_ready[0]), 32'd0);
    chk({tag, "_if_rsp_v"}, 32'(if_rsp_valid[0]), 32'd0);
    chk({tag, "_ls_rsp_v"}, 32'(ls_rsp_valid[0]), 32'd0);
    chk({tag, "_mem_re"},   32'(mem_re[0]),       32'd0);
    chk({tag, "_mem_we"},   32'(mem_we_bm[0]),    32'd0);
    chk({tag, "_mem_addr"}, mem_addr[0],          32'd0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    logic [1:0] e;
    logic       seen;
    rst_n = 1'b1;
    idle_inputs();

    // Reset state, with requests pending to show ready is held low.
    nxt();
    rst_n        = 1'b0;
    if_req_valid = 1'b1;
    ls_req_valid = 1'b1;
    smp();
    chk_quiet0("rst");
    chk("rst_if_data", if_rsp_data[0], 32'd0);
    chk("rst_ls_data", ls_rsp_data[0], 32'd0);

    // Single fetch, MEM_LAT=2.
    do_reset();
    if_req_valid = 1'b1;
    if_req_addr  = 32'h0000_0102;
    smp();
    chk("f_c0_if_ready", 32'(if_req_ready[0]), 32'd1);
    chk("f_c0_ls_ready", 32'(ls_req_ready[0]), 32'd0);
    nxt();
    if_req_valid = 1'b0;
    smp();
    chk("f_c1_mem_re",   32'(mem_re[0]),    32'd1);
    chk("f_c1_mem_addr", mem_addr[0],       32'h0000_0100);
    chk("f_c1_mem_we",   32'(mem_we_bm[0]), 32'd0);
    nxt();
    smp();
    chk("f_c2_mem_re", 32'(mem_re[0]), 32'd0);
    nxt();
    mem_rdata = 32'hDEAD_BEEF;
    smp();
    chk("f_c3_rsp_v", 32'(if_rsp_valid[0]), 32'd0);
    nxt();
    mem_rdata = 32'h0BAD_0BAD;
    smp();
    chk("f_c4_rsp_v",    32'(if_rsp_valid[0]), 32'd1);
    chk("f_c4_rsp_data", if_rsp_data[0],       32'hDEAD_BEEF);
    chk("f_c4_ls_rsp_v", 32'(ls_rsp_valid[0]), 32'd0);
    nxt();
    smp();
    chk("f_c5_rsp_v",    32'(if_rsp_valid[0]), 32'd0);
    chk("f_c5_rsp_hold", if_rsp_data[0],       32'hDEAD_BEEF);

    // Fetch never writes, even with store-looking LSU inputs.
    do_reset();
    if_req_valid = 1'b1;
    if_req_addr  = 32'h0000_0010;
    ls_req_we    = 1'b1;
    ls_req_bm    = 4'hF;
    ls_req_wdata = 32'hFFFF_FFFF;
    nxt();
    if_req_valid = 1'b0;
    smp();
    chk("fw_mem_we", 32'(mem_we_bm[0]), 32'd0);
    chk("fw_mem_re", 32'(mem_re[0]),    32'd1);

    // LSU load, then byte store, then empty-mask store.
    do_reset();
    ls_req_valid = 1'b1;
    ls_req_we    = 1'b0;
    ls_req_addr  = 32'h0000_0206;
    smp();
    chk("ld_ready", 32'(ls_req_ready[0]), 32'd1);
    nxt();
    ls_req_valid = 1'b0;
    smp();
    chk("ld_mem_addr", mem_addr[0],    32'h0000_0204);
    chk("ld_mem_re",   32'(mem_re[0]), 32'd1);
    nxt();
    nxt();
    mem_rdata = 32'h1234_5678;
    nxt();
    mem_rdata = 32'h0;
    smp();
    chk("ld_rsp_v",    32'(ls_rsp_valid[0]), 32'd1);
    chk("ld_rsp_data", ls_rsp_data[0],       32'h1234_5678);
    nxt();
    ls_req_valid = 1'b1;
    ls_req_we    = 1'b1;
    ls_req_addr  = 32'h0000_0203;
    ls_req_wdata = 32'hAB00_0000;
    ls_req_bm    = 4'b1000;
    smp();
    chk("st_ready", 32'(ls_req_ready[0]), 32'd1);
    nxt();
    ls_req_valid = 1'b0;
    smp();
    chk("st_c1_mem_we",    32'(mem_we_bm[0]), 32'h8);
    chk("st_c1_mem_wdata", mem_wdata[0],      32'hAB00_0000);
    chk("st_c1_mem_addr",  mem_addr[0],       32'h0000_0200);
    chk("st_c1_mem_re",    32'(mem_re[0]),    32'd0);
    nxt();
    smp();
    chk("st_c2_rsp_v",    32'(ls_rsp_valid[0]), 32'd1);
    chk("st_c2_rsp_data", ls_rsp_data[0],       32'd0);
    chk("st_c2_mem_re",   32'(mem_re[0]),       32'd0);
    chk("st_c2_mem_we",   32'(mem_we_bm[0]),    32'd0);
    nxt();
    ls_req_valid = 1'b1;
    ls_req_we    = 1'b1;
    ls_req_addr  = 32'h0000_0300;
    ls_req_wdata = 32'h0000_5555;
    ls_req_bm    = 4'b0000;
    smp();
    chk("st_c3_rsp_v",  32'(ls_rsp_valid[0]), 32'd0);
    chk("bm0_ready",    32'(ls_req_ready[0]), 32'd1);
    nxt();
    ls_req_valid = 1'b0;
    smp();
    chk("bm0_mem_we",    32'(mem_we_bm[0]), 32'd0);
    chk("bm0_mem_re",    32'(mem_re[0]),    32'd0);
    chk("bm0_mem_addr",  mem_addr[0],       32'h0000_0300);
    chk("bm0_mem_wdata", mem_wdata[0],      32'h0000_5555);
    nxt();
    smp();
    chk("bm0_rsp_v", 32'(ls_rsp_valid[0]), 32'd1);

    // Continuous tie: round-robin alternates LS,IF; LSU priority keeps LS.
    do_reset();
    if_req_addr = 32'h0000_0400;
    ls_req_addr = 32'h0000_0500;
    ls_req_we   = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if_req_valid = 1'b1;
      ls_req_valid = 1'b1;
      smp();
      if ((c % 5) != 0)            e = 2'b00;
      else if (((c / 5) % 2) == 0) e = 2'b01;
      else                         e = 2'b10;
      chk($sformatf("tie_rr_c%0d", c), 32'({if_req_ready[0], ls_req_ready[0]}), 32'(e));
      e = ((c % 5) == 0) ? 2'b01 : 2'b00;
      chk($sformatf("tie_pr_c%0d", c), 32'({if_req_ready[1], ls_req_ready[1]}), 32'(e));
      nxt();
    end

    // LSU priority for three grants, then LSU drops and IF is served.
    do_reset();
    for (int c = 0; c < 16; c++) begin
      if_req_valid = 1'b1;
      ls_req_valid = (c <= 10);
      smp();
      if ((c % 5) != 0) e = 2'b00;
      else if (c < 15)  e = 2'b01;
      else              e = 2'b10;
      chk($sformatf("prio_c%0d", c), 32'({if_req_ready[1], ls_req_ready[1]}), 32'(e));
      nxt();
    end

    // Reset in the middle of a fetch WAIT.
    do_reset();
    if_req_valid = 1'b1;
    if_req_addr  = 32'h0000_0040;
    nxt();
    if_req_valid = 1'b0;
    nxt();
    rst_n        = 1'b0;
    if_req_valid = 1'b1;
    #1;
    chk_quiet0("mid");
    nxt();
    nxt();
    rst_n        = 1'b1;
    if_req_valid = 1'b0;
    ls_req_valid = 1'b1;
    ls_req_we    = 1'b0;
    ls_req_addr  = 32'h0000_0080;
    smp();
    chk("mid_ls_ready", 32'(ls_req_ready[0]), 32'd1);
    seen = 1'b0;
    for (int c = 1; c < 12; c++) begin
      nxt();
      ls_req_valid = 1'b0;
      mem_rdata    = 32'h7700_0000 + 32'(c);
      smp();
      seen = seen | if_rsp_valid[0];
      if (c == 4) chk("mid_ls_rsp", ls_rsp_data[0], 32'h7700_0003);
    end
    chk("mid_no_if_rsp", 32'(seen), 32'd0);

    // Latency sweep: mem_rdata changes every cycle, only the last WAIT cycle counts.
    do_reset();
    for (int c = 0; c < 20; c++) begin
      ls_req_valid = (c == 0);
      ls_req_we    = 1'b0;
      ls_req_addr  = 32'h0000_0010;
      mem_rdata    = 32'hA000_0000 + 32'(c);
      smp();
      chk($sformatf("sw2_v_c%0d", c),  32'(ls_rsp_valid[0]), 32'(c == 4));
      chk($sformatf("sw1_v_c%0d", c),  32'(ls_rsp_valid[2]), 32'(c == 3));
      chk($sformatf("sw15_v_c%0d", c), 32'(ls_rsp_valid[3]), 32'(c == 17));
      if (c == 4)  chk("sw2_data",  ls_rsp_data[0], 32'hA000_0003);
      if (c == 3)  chk("sw1_data",  ls_rsp_data[2], 32'hA000_0002);
      if (c == 17) chk("sw15_data", ls_rsp_data[3], 32'hA000_0010);
      nxt();
    end
    smp();
    chk("sw1_hold", ls_rsp_data[2], 32'hA000_0002);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
